// File: rtl/serial_bit_shifter.sv
// Parallel-to-serial shifter feeding the sequence detector, one frame bit per clk.
// Optional even-parity bit per frame when SER_PARITY_EN is defined.
module serial_bit_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sout_n, valid_n, done_n;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  // The outgoing bit always sits at the exit end of shreg; done marks the last frame bit.
  assign load_ready = (state == IDLE) || done;
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    sout_n  = sout;
    valid_n = sout_valid;
    done_n  = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      shreg_n = din;
      cnt_n   = '0;
      sout_n  = MSB_FIRST ? din[WIDTH-1] : din[0];
      valid_n = 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != LAST_DATA) begin
            shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            sout_n  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
            cnt_n   = cnt + 1'b1;
            done_n  = (cnt_n == LAST_BIT);
          end else begin
`ifdef SER_PARITY_EN
            state_n = PARITY;
            sout_n  = par_q;
            cnt_n   = cnt + 1'b1;
            done_n  = 1'b1;
`else
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
            sout_n  = 1'b0;
            valid_n = 1'b0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          state_n = IDLE;
          shreg_n = '0;
          cnt_n   = '0;
          sout_n  = 1'b0;
          valid_n = 1'b0;
        end
`endif
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      sout       <= sout_n;
      sout_valid <= valid_n;
      done       <= done_n;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        par_q <= 1'b0;
    else if (accept) par_q <= ^din;
  end
`endif

endmodule

// File: tb/tb_serial_bit_shifter.sv
// Randomised bench for serial_bit_shifter: MSB-first and LSB-first instances checked
// against a queue-of-bits reference model (honours SER_PARITY_EN).
module tb_serial_bit_shifter;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;

  logic ready_m, sout_m, valid_m, busy_m, done_m;
  logic ready_l, sout_l, valid_l, busy_l, done_l;
  logic [4:0] obs_m, obs_l;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the bits still to appear on sout, front = bit currently on sout.
  bit q_msb[$];
  bit q_lsb[$];

  always #5 clk = ~clk;

  serial_bit_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(ready_m),
    .sout(sout_m), .sout_valid(valid_m), .busy(busy_m), .done(done_m)
  );

  serial_bit_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(ready_l),
    .sout(sout_l), .sout_valid(valid_l), .busy(busy_l), .done(done_l)
  );

  assign obs_m = {sout_m, valid_m, busy_m, done_m, ready_m};
  assign obs_l = {sout_l, valid_l, busy_l, done_l, ready_l};

  // Expected {sout, sout_valid, busy, done, load_ready} from the model queue.
  function automatic logic [4:0] model_out(input bit lsb);
    int  n;
    bit  front;
    logic [4:0] v;
    n     = lsb ? q_lsb.size() : q_msb.size();
    front = 1'b0;
    if (n > 0) front = lsb ? q_lsb[0] : q_msb[0];
    v[4] = (n > 0) ? front : 1'b0;
    v[3] = (n > 0);
    v[2] = (n > 0);
    v[1] = (n == 1);
    v[0] = (n <= 1);
    return v;
  endfunction

  function automatic void push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      q_msb.push_back(d[W-1-i]);
      q_lsb.push_back(d[i]);
    end
`ifdef SER_PARITY_EN
    q_msb.push_back(^d);
    q_lsb.push_back(^d);
`endif
  endfunction

  // Drives one cycle from a negedge, advances the model at the posedge, returns at next negedge.
  task automatic drive(input logic v, input logic [W-1:0] d);
    bit acc;
    load_valid = v;
    din        = d;
    acc        = v && (q_msb.size() <= 1);
    @(posedge clk);
    if (q_msb.size() > 0) begin
      void'(q_msb.pop_front());
      void'(q_lsb.pop_front());
    end
    if (acc) push_frame(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run += 2;
    if (obs_m !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold msb: got %b want %b", obs_m, 5'b00001);
    end
    if (obs_l !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold lsb: got %b want %b", obs_l, 5'b00001);
    end
    rst = 1'b1;
    drive(1'b0, '0);
    tests_run += 2;
    if (obs_m !== model_out(1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL reset_release msb: got %b want %b", obs_m, model_out(1'b0));
    end
    if (obs_l !== model_out(1'b1)) begin
      tests_failed++;
      $display("[TB] FAIL reset_release lsb: got %b want %b", obs_l, model_out(1'b1));
    end
  endtask

  task automatic test_single_word(input logic [W-1:0] d, input logic [F-1:0] want_bits);
    logic [F-1:0] got;
    int n;
    got = '0;
    n   = 0;
    for (int c = 0; c < F + 2; c++) begin
      drive(c == 0, d);
      tests_run += 2;
      if (obs_m !== model_out(1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL single_word msb cyc%0d: got %b want %b", c, obs_m, model_out(1'b0));
      end
      if (obs_l !== model_out(1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL single_word lsb cyc%0d: got %b want %b", c, obs_l, model_out(1'b1));
      end
      if (valid_m === 1'b1) begin
        got = {got[F-2:0], sout_m};
        n++;
      end
    end
    tests_run++;
    if (got !== want_bits || n != F) begin
      tests_failed++;
      $display("[TB] FAIL single_word_bits: got %b (%0d bits) want %b (%0d bits)", got, n, want_bits, F);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [2];
    int idx, vcount;
    bit acc;
    words[0] = 8'hFF;
    words[1] = 8'h0F;
    idx      = 0;
    vcount   = 0;
    for (int c = 0; c < 2 * F + 4; c++) begin
      acc = (idx < 2) && (q_msb.size() <= 1);
      drive(idx < 2, (idx < 2) ? words[idx] : 8'h00);
      if (acc) idx++;
      tests_run += 2;
      if (obs_m !== model_out(1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back msb cyc%0d: got %b want %b", c, obs_m, model_out(1'b0));
      end
      if (obs_l !== model_out(1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back lsb cyc%0d: got %b want %b", c, obs_l, model_out(1'b1));
      end
      if (valid_m === 1'b1) vcount++;
    end
    tests_run++;
    if (vcount != 2 * F) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_len: got %0d valid bits want %0d", vcount, 2 * F);
    end
  endtask

  task automatic test_ignored_load();
    for (int c = 0; c < F + 3; c++) begin
      if (c == 0)      drive(1'b1, 8'hB4);
      else if (c == 3) drive(1'b1, 8'h5A);
      else             drive(1'b0, 8'h00);
      tests_run += 2;
      if (obs_m !== model_out(1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL ignored_load msb cyc%0d: got %b want %b", c, obs_m, model_out(1'b0));
      end
      if (obs_l !== model_out(1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL ignored_load lsb cyc%0d: got %b want %b", c, obs_l, model_out(1'b1));
      end
    end
  endtask

  task automatic test_reset_mid_frame(input logic [F-1:0] want_lsb);
    logic [F-1:0] got;
    int n;
    drive(1'b1, 8'hB4);
    repeat (3) drive(1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    tests_run += 2;
    if (obs_m !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL async_reset msb: got %b want %b", obs_m, 5'b00001);
    end
    if (obs_l !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL async_reset lsb: got %b want %b", obs_l, 5'b00001);
    end
    @(negedge clk);
    q_msb.delete();
    q_lsb.delete();
    rst = 1'b1;
    got = '0;
    n   = 0;
    for (int c = 0; c < F + 3; c++) begin
      drive(c == 1, 8'h01);
      tests_run += 2;
      if (obs_m !== model_out(1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL after_reset msb cyc%0d: got %b want %b", c, obs_m, model_out(1'b0));
      end
      if (obs_l !== model_out(1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL after_reset lsb cyc%0d: got %b want %b", c, obs_l, model_out(1'b1));
      end
      if (valid_l === 1'b1) begin
        got = {got[F-2:0], sout_l};
        n++;
      end
    end
    tests_run++;
    if (got !== want_lsb || n != F) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_bits: got %b (%0d bits) want %b (%0d bits)", got, n, want_lsb, F);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom));
      tests_run += 2;
      if (obs_m !== model_out(1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL random msb cyc%0d: got %b want %b", c, obs_m, model_out(1'b0));
      end
      if (obs_l !== model_out(1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL random lsb cyc%0d: got %b want %b", c, obs_l, model_out(1'b1));
      end
    end
    repeat (F + 1) drive(1'b0, '0);
    tests_run++;
    if (obs_m !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL random_drain: got %b want %b", obs_m, 5'b00001);
    end
  endtask

  initial begin
    test_reset();
`ifdef SER_PARITY_EN
    test_single_word(8'hB4, {8'hB4, 1'b0});
    test_single_word(8'hB5, {8'hB5, 1'b1});
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame({8'h80, 1'b1});
`else
    test_single_word(8'hB4, 8'hB4);
    test_single_word(8'hB5, 8'hB5);
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame(8'h80);
`endif
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
